axi_rd_scoreboard: RTL and testbench
====================================

Name: axi_rd_scoreboard

Overview:
- Passive, parametrised AXI4 read-channel checker for formal and simulation harnesses of the cache and memory path.
- Monitors one AR/R interface, for example between axi_icache and axi_ram. Compares every R beat against a golden pattern memory where word k holds k, zero-extended.
- Tracks multiple outstanding bursts (arlen > 0) and checks handshake stability.
- Reports the first error with a code and address; a formal harness asserts !o_err.

Parameters:
- ADDR_WIDTH, 8, AXI address width.
- DATA_WIDTH, 32, data width; power of 2, at least 8.
- ID_WIDTH, 4, AXI ID width.
- DEPTH, 4, maximum outstanding accepted AR transactions; power of 2.
- MAX_LEN, 16, largest legal burst length in beats (arlen+1); 1..256.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_arvalid, i_arready  in  1  monitored AR handshake.
- i_araddr  in  ADDR_WIDTH  AR address.
- i_arid  in  ID_WIDTH  AR ID.
- i_arlen  in  8  AR burst length minus 1.
- i_arsize  in  3  AR beat size.
- i_arburst  in  2  AR burst type.
- i_rvalid, i_rready  in  1  monitored R handshake.
- i_rdata  in  DATA_WIDTH  R data.
- i_rresp  in  2  R response.
- i_rlast  in  1  R last-beat flag.
- i_rid  in  ID_WIDTH  R ID.
- o_err  out  1  sticky error flag.
- o_err_code  out  4  code of the first error.
- o_err_addr  out  ADDR_WIDTH  expected beat address (R errors) or araddr (AR errors) at the first error.
- o_outstanding  out  $clog2(DEPTH+1)  accepted bursts not yet completed.
- o_txn_cnt  out  16  completed bursts, saturating.
- o_beat_cnt  out  16  accepted R beats, saturating.

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, FIFO empty, beat counter 0, stability shadows cleared. Reset mid-burst discards all tracking; no error is raised for the abandoned burst.
- AR accept (arvalid && arready):
  - Push {addr, id, len, size, burst} into an in-order FIFO of DEPTH entries.
  - Unsupported if arburst is not FIXED (0) or INCR (1), arsize is not log2(DATA_WIDTH/8), or arlen+1 > MAX_LEN. Flag code 10 and do not push.
- R tracking: head-of-FIFO state holds cur_addr and beat_idx. On the first beat of a burst, cur_addr = head addr aligned down to the word boundary.
- Per R beat (rvalid && rready), all checks in the same cycle:
  - FIFO empty: code 5. An AR accepted in the same cycle does not satisfy the R.
  - rid != head id: code 4.
  - rresp != 0: code 9.
  - rdata != cur_addr >> log2(DATA_WIDTH/8), zero-extended: code 1.
  - rlast=1 with beat_idx < len: code 2. Pop the FIFO anyway to resynchronise.
  - rlast=0 with beat_idx == len: code 3. Pop the FIFO; treat the next beat as the next burst.
  - Otherwise: beat_idx++; for INCR, cur_addr += DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH; for FIXED, cur_addr is unchanged.
  - On the final beat: pop, o_txn_cnt++, beat_idx = 0.
- Overflow: AR accept while the FIFO is full and no pop in the same cycle gives code 6 and the entry is dropped. Push and pop in the same cycle when full is legal.
- Stability (AXI hold rules):
  - Code 7: arvalid && !arready in cycle N, then in N+1 arvalid drops or any AR payload changes.
  - Code 8: the same rule on R (rvalid, rdata, rresp, rlast, rid).
- Error capture:
  - o_err is set the cycle after the first error and stays set until reset.
  - o_err_code and o_err_addr latch only the first error.
  - If several errors occur in one cycle, report the lowest code among 1..10.
  - Checking continues after an error; counters keep running.
- Latency: all outputs are registered and valid one cycle after the triggering handshake. o_outstanding = FIFO occupancy.
- Counters saturate at 16'hFFFF.
- rready/arready low: no action. Only handshake cycles count.

Test Plan:
- Single beat: AR addr 0x14, len 0, size 2, INCR; R rdata 5, rlast 1 -> o_err 0, o_txn_cnt 1, o_outstanding 0.
- INCR burst: AR addr 0x20, len 3; R data 8, 9, 10, 11 with rlast on the 4th beat and random rvalid gaps -> no error, o_beat_cnt 4. Repeat at addr 0xF8, len 3 -> expected 62, 63, 0, 1 (address wrap), no error.
- Outstanding: 4 ARs back-to-back (addr 0x00, 0x10, 0x40, 0x80, len 1), then R in order -> o_outstanding peaks at 4, ends 0, no error. A 5th AR while full with no pop -> o_err_code 6.
- Data error: AR 0x08 len 0; R rdata 3 -> o_err 1, code 1, o_err_addr 0x08. A later good burst -> o_err_code is still 1 and o_txn_cnt increments.
- Protocol errors:
  - rlast on beat 1 of a len-2 burst -> code 2.
  - arvalid dropped while arready is low -> code 7.
  - R with no outstanding AR -> code 5.
  - arburst 2 (WRAP) -> code 10.
- Reset mid-burst: assert i_rst_n low after 2 of 4 beats -> all outputs 0 immediately; a new burst after reset passes.

Source files
------------

// File: rtl/axi_rd_scoreboard.sv
// Passive AXI4 read-channel checker: compares R beats against a pattern memory where word k
// holds k, tracks in-order outstanding bursts and AR/R hold rules, and latches the first error.
module axi_rd_scoreboard #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MAX_LEN    = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_arvalid,
  input  logic                         i_arready,
  input  logic [ADDR_WIDTH-1:0]        i_araddr,
  input  logic [ID_WIDTH-1:0]          i_arid,
  input  logic [7:0]                   i_arlen,
  input  logic [2:0]                   i_arsize,
  input  logic [1:0]                   i_arburst,
  input  logic                         i_rvalid,
  input  logic                         i_rready,
  input  logic [DATA_WIDTH-1:0]        i_rdata,
  input  logic [1:0]                   i_rresp,
  input  logic                         i_rlast,
  input  logic [ID_WIDTH-1:0]          i_rid,
  output logic                         o_err,
  output logic [3:0]                   o_err_code,
  output logic [ADDR_WIDTH-1:0]        o_err_addr,
  output logic [$clog2(DEPTH+1)-1:0]   o_outstanding,
  output logic [15:0]                  o_txn_cnt,
  output logic [15:0]                  o_beat_cnt
);

  localparam int unsigned Bytes   = DATA_WIDTH / 8;
  localparam int unsigned Lsb     = $clog2(Bytes);
  localparam int unsigned PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW    = $clog2(DEPTH + 1);
  localparam int unsigned CmpW    = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned ArPayW  = ADDR_WIDTH + ID_WIDTH + 13;
  localparam int unsigned RPayW   = DATA_WIDTH + ID_WIDTH + 3;

  logic [ADDR_WIDTH-1:0] fifo_addr_q [DEPTH];
  logic [ID_WIDTH-1:0]   fifo_id_q   [DEPTH];
  logic [7:0]            fifo_len_q  [DEPTH];
  logic                  fifo_incr_q [DEPTH];

  logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [7:0]            beat_idx_q, beat_idx_d;
  logic                  ar_hold_q, r_hold_q;
  logic [ArPayW-1:0]     ar_shadow_q;
  logic [RPayW-1:0]      r_shadow_q;
  logic                  err_q, err_d;
  logic [3:0]            err_code_q, err_code_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [15:0]           txn_q, txn_d, beat_cnt_q, beat_cnt_d;

  logic                  ar_hs, r_hs, empty, full, ar_bad, push, pop, last_beat;
  logic [ADDR_WIDTH-1:0] head_addr, head_aligned, beat_addr, r_err_addr;
  logic [ID_WIDTH-1:0]   head_id;
  logic [7:0]            head_len;
  logic                  head_incr;
  logic [ArPayW-1:0]     ar_pay;
  logic [RPayW-1:0]      r_pay;
  logic [10:1]           err_vec;
  logic [3:0]            first_code;

  assign ar_hs        = i_arvalid & i_arready;
  assign r_hs         = i_rvalid & i_rready;
  assign empty        = (cnt_q == '0);
  assign full         = (cnt_q == CntW'(DEPTH));
  assign head_addr    = fifo_addr_q[rptr_q];
  assign head_id      = fifo_id_q[rptr_q];
  assign head_len     = fifo_len_q[rptr_q];
  assign head_incr    = fifo_incr_q[rptr_q];
  assign head_aligned = head_addr & ~ADDR_WIDTH'(Bytes - 1);
  // First beat of a burst takes its address from the FIFO head, later beats from cur_addr.
  assign beat_addr    = (beat_idx_q == 8'd0) ? head_aligned : cur_addr_q;
  assign r_err_addr   = empty ? '0 : beat_addr;
  assign ar_pay       = {i_araddr, i_arid, i_arlen, i_arsize, i_arburst};
  assign r_pay        = {i_rdata, i_rresp, i_rlast, i_rid};
  assign ar_bad       = i_arburst[1] || (i_arsize != 3'(Lsb)) ||
                        ({1'b0, i_arlen} >= 9'(MAX_LEN));

  always_comb begin
    err_vec    = '0;
    pop        = 1'b0;
    push       = 1'b0;
    beat_idx_d = beat_idx_q;
    cur_addr_d = cur_addr_q;
    last_beat  = (beat_idx_q == head_len);
    if (r_hs) begin
      if (empty) begin
        err_vec[5] = 1'b1;
      end else begin
        err_vec[4] = (i_rid != head_id);
        err_vec[9] = (i_rresp != 2'b00);
        err_vec[1] = (CmpW'(i_rdata) != CmpW'(beat_addr >> Lsb));
        err_vec[2] = i_rlast && !last_beat;
        err_vec[3] = !i_rlast && last_beat;
        // Either end marker retires the burst so checking resynchronises on the next one.
        if (i_rlast || last_beat) begin
          pop        = 1'b1;
          beat_idx_d = 8'd0;
        end else begin
          beat_idx_d = beat_idx_q + 8'd1;
          cur_addr_d = head_incr ? beat_addr + ADDR_WIDTH'(Bytes) : beat_addr;
        end
      end
    end
    if (ar_hs) begin
      if (ar_bad) begin
        err_vec[10] = 1'b1;
      end else if (full && !pop) begin
        err_vec[6] = 1'b1;
      end else begin
        push = 1'b1;
      end
    end
    err_vec[7] = ar_hold_q && (!i_arvalid || (ar_pay != ar_shadow_q));
    err_vec[8] = r_hold_q && (!i_rvalid || (r_pay != r_shadow_q));
  end

  always_comb begin
    first_code = 4'd0;
    for (int i = 10; i >= 1; i--) begin
      if (err_vec[i]) first_code = 4'(i);
    end
    err_d      = err_q;
    err_code_d = err_code_q;
    err_addr_d = err_addr_q;
    if (!err_q && (err_vec != '0)) begin
      err_d      = 1'b1;
      err_code_d = first_code;
      unique case (first_code)
        4'd6, 4'd7, 4'd10: err_addr_d = i_araddr;
        default:           err_addr_d = r_err_addr;
      endcase
    end
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = (wptr_q == PtrW'(DEPTH - 1)) ? '0 : wptr_q + PtrW'(1);
    if (pop)  rptr_d = (rptr_q == PtrW'(DEPTH - 1)) ? '0 : rptr_q + PtrW'(1);
    if (push && !pop) cnt_d = cnt_q + CntW'(1);
    if (pop && !push) cnt_d = cnt_q - CntW'(1);
    txn_d      = (pop && (txn_q != 16'hFFFF)) ? txn_q + 16'd1 : txn_q;
    beat_cnt_d = (r_hs && (beat_cnt_q != 16'hFFFF)) ? beat_cnt_q + 16'd1 : beat_cnt_q;
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_addr_q[wptr_q] <= i_araddr;
      fifo_id_q[wptr_q]   <= i_arid;
      fifo_len_q[wptr_q]  <= i_arlen;
      fifo_incr_q[wptr_q] <= i_arburst[0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      cur_addr_q  <= '0;
      beat_idx_q  <= '0;
      ar_hold_q   <= 1'b0;
      r_hold_q    <= 1'b0;
      ar_shadow_q <= '0;
      r_shadow_q  <= '0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      err_addr_q  <= '0;
      txn_q       <= '0;
      beat_cnt_q  <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      cur_addr_q  <= cur_addr_d;
      beat_idx_q  <= beat_idx_d;
      ar_hold_q   <= i_arvalid & ~i_arready;
      r_hold_q    <= i_rvalid & ~i_rready;
      ar_shadow_q <= ar_pay;
      r_shadow_q  <= r_pay;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      err_addr_q  <= err_addr_d;
      txn_q       <= txn_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign o_err         = err_q;
  assign o_err_code    = err_code_q;
  assign o_err_addr    = err_addr_q;
  assign o_outstanding = cnt_q;
  assign o_txn_cnt     = txn_q;
  assign o_beat_cnt    = beat_cnt_q;

endmodule

// File: tb/tb_axi_rd_scoreboard.sv
// Bench for axi_rd_scoreboard: directed scenarios plus randomized AR/R traffic, checked every
// cycle against a queue-based model of the checker's rules.
module tb_axi_rd_scoreboard;

  localparam int DEPTH = 4;
  localparam int MAXL  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arvalid = 0, arready = 0, rvalid = 0, rready = 0, rlast = 0;
  logic [7:0]  araddr = 0, arlen = 0;
  logic [3:0]  arid = 0, rid = 0;
  logic [2:0]  arsize = 0;
  logic [1:0]  arburst = 0, rresp = 0;
  logic [31:0] rdata = 0;
  logic        o_err;
  logic [3:0]  o_err_code;
  logic [7:0]  o_err_addr;
  logic [2:0]  o_outstanding;
  logic [15:0] o_txn_cnt, o_beat_cnt;

  always #5 clk = ~clk;

  axi_rd_scoreboard dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_arvalid(arvalid), .i_arready(arready), .i_araddr(araddr), .i_arid(arid),
    .i_arlen(arlen), .i_arsize(arsize), .i_arburst(arburst),
    .i_rvalid(rvalid), .i_rready(rready), .i_rdata(rdata), .i_rresp(rresp),
    .i_rlast(rlast), .i_rid(rid),
    .o_err(o_err), .o_err_code(o_err_code), .o_err_addr(o_err_addr),
    .o_outstanding(o_outstanding), .o_txn_cnt(o_txn_cnt), .o_beat_cnt(o_beat_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: list of accepted bursts and beats already seen for the head burst.
  typedef struct {
    logic [7:0] addr;
    logic [3:0] id;
    int         len;
    bit         incr;
  } burst_t;

  burst_t      q[$];
  int          m_done, m_txn, m_beat, m_code;
  bit          m_err;
  logic [7:0]  m_addr;
  bit          p_ar_wait, p_r_wait;
  logic [24:0] p_ar;
  logic [38:0] p_r;

  function automatic logic [7:0] m_exp_addr();
    logic [7:0] base;
    if (q.size() == 0) return 8'h00;
    base = q[0].addr & 8'hFC;
    return q[0].incr ? base + 8'(4 * m_done) : base;
  endfunction

  task automatic model_reset();
    q.delete();
    m_done = 0; m_txn = 0; m_beat = 0; m_code = 0; m_err = 0; m_addr = 0;
    p_ar_wait = 0; p_r_wait = 0; p_ar = 0; p_r = 0;
  endtask

  task automatic model_step();
    logic [10:0] e;
    int          orig;
    bit          popped, last;
    logic [7:0]  ea;
    burst_t      b;
    e = '0; orig = q.size(); popped = 0; ea = m_exp_addr();
    if (rvalid && rready) begin
      if (m_beat < 65535) m_beat++;
      if (orig == 0) begin
        e[5] = 1;
      end else begin
        if (rid != q[0].id) e[4] = 1;
        if (rresp != 2'd0) e[9] = 1;
        if (rdata != 32'(ea >> 2)) e[1] = 1;
        last = (m_done == q[0].len);
        if (rlast && !last) e[2] = 1;
        if (!rlast && last) e[3] = 1;
        if (rlast || last) begin
          q.delete(0); m_done = 0; popped = 1;
          if (m_txn < 65535) m_txn++;
        end else begin
          m_done++;
        end
      end
    end
    if (arvalid && arready) begin
      if (arburst > 2'd1 || arsize != 3'd2 || int'(arlen) >= MAXL) e[10] = 1;
      else if (orig == DEPTH && !popped) e[6] = 1;
      else begin
        b.addr = araddr; b.id = arid; b.len = int'(arlen); b.incr = (arburst == 2'd1);
        q.push_back(b);
      end
    end
    if (p_ar_wait && (!arvalid || {araddr, arid, arlen, arsize, arburst} != p_ar)) e[7] = 1;
    if (p_r_wait && (!rvalid || {rdata, rresp, rlast, rid} != p_r)) e[8] = 1;
    if (!m_err && e != 0) begin
      m_err = 1;
      for (int c = 10; c >= 1; c--) if (e[c]) m_code = c;
      m_addr = (m_code == 6 || m_code == 7 || m_code == 10) ? araddr : ea;
    end
    p_ar_wait = arvalid && !arready;
    p_r_wait  = rvalid && !rready;
    p_ar      = {araddr, arid, arlen, arsize, arburst};
    p_r       = {rdata, rresp, rlast, rid};
  endtask

  task automatic compare_all();
    check_eq("outstanding", 32'(o_outstanding), 32'(q.size()));
    check_eq("err", 32'(o_err), 32'(m_err));
    check_eq("err_code", 32'(o_err_code), 32'(m_code));
    check_eq("err_addr", 32'(o_err_addr), 32'(m_addr));
    check_eq("txn_cnt", 32'(o_txn_cnt), 32'(m_txn));
    check_eq("beat_cnt", 32'(o_beat_cnt), 32'(m_beat));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    arvalid = 0; arready = 0; rvalid = 0; rready = 0; rlast = 0;
    araddr = 0; arlen = 0; arid = 0; arsize = 0; arburst = 0;
    rdata = 0; rresp = 0; rid = 0;
    rst_n = 0;
    #1;
    check_eq("rst_err", 32'(o_err), 0);
    check_eq("rst_code", 32'(o_err_code), 0);
    check_eq("rst_addr", 32'(o_err_addr), 0);
    check_eq("rst_outstanding", 32'(o_outstanding), 0);
    check_eq("rst_txn", 32'(o_txn_cnt), 0);
    check_eq("rst_beat", 32'(o_beat_cnt), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic do_ar(input logic [7:0] addr, input logic [3:0] id, input logic [7:0] len,
                       input logic [1:0] burst);
    bit hs = 0;
    arvalid = 1; araddr = addr; arid = id; arlen = len; arsize = 3'd2; arburst = burst;
    for (int i = 0; i < 8 && !hs; i++) begin
      arready = (i >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      hs = arready;
      tick();
    end
    arvalid = 0; arready = 0;
  endtask

  task automatic do_r(input logic [31:0] data, input logic [3:0] id, input logic last,
                      input int gaps);
    bit hs = 0;
    rvalid = 0;
    for (int i = 0; i < gaps; i++) begin
      rready = 1'($urandom_range(0, 1));
      tick();
    end
    rvalid = 1; rdata = data; rid = id; rlast = last; rresp = 2'd0;
    for (int i = 0; i < 8 && !hs; i++) begin
      rready = (i >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      hs = rready;
      tick();
    end
    rvalid = 0; rready = 0;
  endtask

  task automatic rand_cycle(input bit corrupt);
    if (arvalid && arready) arvalid = 0;
    else if (arvalid && corrupt && $urandom_range(0, 29) == 0) arvalid = 0;
    if (!arvalid && $urandom_range(0, 2) == 0 && (corrupt || q.size() < DEPTH)) begin
      arvalid = 1;
      araddr  = 8'($urandom);
      arid    = 4'($urandom);
      arlen   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 3));
      arsize  = 3'd2;
      arburst = 2'($urandom_range(0, 1));
      if (corrupt && $urandom_range(0, 14) == 0) begin
        case ($urandom_range(0, 2))
          0:       arburst = 2'd2;
          1:       arlen   = 8'd20;
          default: arsize  = 3'd1;
        endcase
      end
    end
    arready = 1'($urandom_range(0, 1));
    if (rvalid && rready) rvalid = 0;
    else if (rvalid && corrupt && $urandom_range(0, 29) == 0) rvalid = 0;
    if (!rvalid && $urandom_range(0, 1) == 0 &&
        (q.size() > 0 || (corrupt && $urandom_range(0, 19) == 0))) begin
      rvalid = 1;
      rresp  = 2'd0;
      rdata  = 32'(m_exp_addr() >> 2);
      rid    = (q.size() > 0) ? q[0].id : 4'($urandom);
      rlast  = (q.size() > 0) ? (m_done == q[0].len) : 1'b1;
      if (corrupt && $urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0:       rdata = rdata ^ 32'd1;
          1:       rlast = ~rlast;
          2:       rresp = 2'd2;
          default: rid   = rid ^ 4'd1;
        endcase
      end
    end
    rready = 1'($urandom_range(0, 1));
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    int peak;
    model_reset();
    do_reset();

    // Single beat
    do_ar(8'h14, 4'd1, 8'd0, 2'd1);
    do_r(32'd5, 4'd1, 1'b1, 0);
    check_eq("single_err", 32'(o_err), 0);
    check_eq("single_txn", 32'(o_txn_cnt), 1);
    check_eq("single_outstanding", 32'(o_outstanding), 0);

    // INCR bursts, second one wraps the address space
    do_reset();
    do_ar(8'h20, 4'd2, 8'd3, 2'd1);
    for (int k = 0; k < 4; k++) do_r(32'(8 + k), 4'd2, k == 3, $urandom_range(0, 2));
    check_eq("incr_err", 32'(o_err), 0);
    check_eq("incr_beats", 32'(o_beat_cnt), 4);
    do_ar(8'hF8, 4'd3, 8'd3, 2'd1);
    do_r(32'd62, 4'd3, 1'b0, 1);
    do_r(32'd63, 4'd3, 1'b0, 0);
    do_r(32'd0, 4'd3, 1'b0, 2);
    do_r(32'd1, 4'd3, 1'b1, 0);
    check_eq("wrap_err", 32'(o_err), 0);
    check_eq("wrap_txn", 32'(o_txn_cnt), 2);

    // Outstanding bursts and overflow
    do_reset();
    do_ar(8'h00, 4'd0, 8'd1, 2'd1);
    do_ar(8'h10, 4'd1, 8'd1, 2'd1);
    do_ar(8'h40, 4'd2, 8'd1, 2'd1);
    do_ar(8'h80, 4'd3, 8'd1, 2'd1);
    peak = int'(o_outstanding);
    check_eq("out_peak", 32'(peak), 4);
    do_r(32'd0, 4'd0, 1'b0, 0);  do_r(32'd1, 4'd0, 1'b1, 0);
    do_r(32'd4, 4'd1, 1'b0, 0);  do_r(32'd5, 4'd1, 1'b1, 0);
    do_r(32'd16, 4'd2, 1'b0, 0); do_r(32'd17, 4'd2, 1'b1, 0);
    do_r(32'd32, 4'd3, 1'b0, 0); do_r(32'd33, 4'd3, 1'b1, 0);
    check_eq("out_end", 32'(o_outstanding), 0);
    check_eq("out_err", 32'(o_err), 0);
    for (int k = 0; k < 4; k++) do_ar(8'(16 * k), 4'(k), 8'd0, 2'd1);
    do_ar(8'hC4, 4'd5, 8'd0, 2'd1);
    check_eq("ovf_code", 32'(o_err_code), 6);
    check_eq("ovf_addr", 32'(o_err_addr), 32'h C4);
    check_eq("ovf_outstanding", 32'(o_outstanding), 4);

    // Data error, then a clean burst
    do_reset();
    do_ar(8'h08, 4'd4, 8'd0, 2'd1);
    do_r(32'd3, 4'd4, 1'b1, 0);
    check_eq("data_err", 32'(o_err), 1);
    check_eq("data_code", 32'(o_err_code), 1);
    check_eq("data_addr", 32'(o_err_addr), 32'h08);
    do_ar(8'h30, 4'd4, 8'd0, 2'd1);
    do_r(32'd12, 4'd4, 1'b1, 0);
    check_eq("data_code_sticky", 32'(o_err_code), 1);
    check_eq("data_txn", 32'(o_txn_cnt), 2);

    // Early rlast
    do_reset();
    do_ar(8'h00, 4'd6, 8'd2, 2'd1);
    do_r(32'd0, 4'd6, 1'b0, 0);
    do_r(32'd1, 4'd6, 1'b1, 0);
    check_eq("early_last_code", 32'(o_err_code), 2);
    check_eq("early_last_addr", 32'(o_err_addr), 32'h04);
    check_eq("early_last_outstanding", 32'(o_outstanding), 0);

    // arvalid dropped while stalled
    do_reset();
    arvalid = 1; araddr = 8'h44; arid = 4'd1; arlen = 8'd0; arsize = 3'd2; arburst = 2'd1;
    arready = 0;
    tick();
    arvalid = 0;
    tick();
    check_eq("ar_drop_code", 32'(o_err_code), 7);
    check_eq("ar_drop_addr", 32'(o_err_addr), 32'h44);

    // R with nothing outstanding
    do_reset();
    do_r(32'd0, 4'd0, 1'b1, 0);
    check_eq("orphan_code", 32'(o_err_code), 5);

    // WRAP burst is unsupported
    do_reset();
    do_ar(8'h50, 4'd2, 8'd3, 2'd2);
    check_eq("wrap_burst_code", 32'(o_err_code), 10);
    check_eq("wrap_burst_addr", 32'(o_err_addr), 32'h50);
    check_eq("wrap_burst_outstanding", 32'(o_outstanding), 0);

    // Reset in the middle of a burst
    do_reset();
    do_ar(8'h20, 4'd1, 8'd3, 2'd1);
    do_r(32'd8, 4'd1, 1'b0, 0);
    do_r(32'd9, 4'd1, 1'b0, 0);
    rvalid = 1; rready = 1; rdata = 32'd10; rid = 4'd1;
    do_reset();
    do_ar(8'h40, 4'd2, 8'd0, 2'd1);
    do_r(32'd16, 4'd2, 1'b1, 0);
    check_eq("post_reset_err", 32'(o_err), 0);
    check_eq("post_reset_txn", 32'(o_txn_cnt), 1);

    // Randomized legal traffic
    do_reset();
    for (int c = 0; c < 1500; c++) rand_cycle(1'b0);
    arvalid = 0; rvalid = 0;
    check_eq("clean_err", 32'(o_err), 0);
    check_eq("clean_has_txns", 32'(o_txn_cnt != 0), 1);

    // Randomized traffic with injected faults
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int c = 0; c < 300; c++) rand_cycle(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
